// File: rtl/branch_resolver.sv
// branch_resolver: resolves exec-stage branches into a registered fetch redirect and a predictor update pulse.
module branch_resolver #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic                 in_is_cond,
  input  logic                 in_is_jump,
  input  logic [31:0]          in_target,
  input  logic                 in_cond_equal,
  input  logic                 in_cond_sign,
  input  logic                 in_negate,
  input  logic                 in_mask_equal,
  input  logic                 in_mask_sign,
  input  logic                 in_pred_taken,
  input  logic [31:0]          in_pred_target,
  input  logic                 in_ds_present,
  input  logic                 ds_valid,
  input  logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  input  logic                 redirect_ready,
  output logic                 upd_valid,
  output logic [31:0]          upd_pc,
  output logic [31:0]          upd_target,
  output logic                 upd_taken,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT_DS, REDIRECT} state_t;
  state_t state, state_nx;
  logic hit, taken, mispredict, accept;
  logic [31:0] next_pc;
  assign in_ready = state == IDLE;
  assign redirect_valid = state == REDIRECT;
  always_comb begin
    hit = (in_mask_equal & in_cond_equal) | (in_mask_sign & in_cond_sign);
    taken = in_is_jump | (in_is_cond & (hit ^ in_negate));
    next_pc = taken ? in_target : in_pc + 32'd8;
    mispredict = (taken != in_pred_taken) | (taken & (in_pred_target != in_target));
    accept = in_valid & in_ready & ~flush;
    state_nx = state;
    if (flush)
      state_nx = IDLE;
    else if (state == IDLE)
      state_nx = accept & mispredict ? (in_ds_present ? REDIRECT : WAIT_DS) : IDLE;
    else if (state == WAIT_DS)
      state_nx = ds_valid ? REDIRECT : WAIT_DS;
    else
      state_nx = redirect_ready ? IDLE : REDIRECT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  // redirect_pc is only written on a mispredicted accept, so it stays stable while REDIRECT waits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      redirect_pc    <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_target     <= '0;
      upd_taken      <= 1'b0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      upd_valid <= accept;
      if (accept) begin
        upd_pc     <= in_pc;
        upd_target <= in_target;
        upd_taken  <= taken;
        branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      end
      if (accept & mispredict) begin
        redirect_pc    <= next_pc;
        mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
      end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed scenarios plus random traffic checked against a MIPS-semantics reference model.
module tb_branch_resolver;
  localparam int CW = 4;
  typedef enum int {BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, JMP, NOP} op_t;
  logic clk = 0, rst_n = 0;
  logic in_valid, in_ready, in_is_cond, in_is_jump, in_cond_equal, in_cond_sign;
  logic in_negate, in_mask_equal, in_mask_sign, in_pred_taken, in_ds_present;
  logic ds_valid, flush, redirect_valid, redirect_ready, upd_valid, upd_taken;
  logic [31:0] in_pc, in_target, in_pred_target, redirect_pc, upd_pc, upd_target;
  logic [CW-1:0] branch_cnt, mispredict_cnt;
  int vecs = 0, errs = 0;
  logic ref_taken;
  int m_st;
  logic m_uv, m_ut;
  logic [31:0] m_rpc, m_upc, m_utgt;
  logic [CW-1:0] m_bc, m_mc;
  always #5 clk = ~clk;
  branch_resolver #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_is_cond(in_is_cond), .in_is_jump(in_is_jump), .in_target(in_target),
    .in_cond_equal(in_cond_equal), .in_cond_sign(in_cond_sign), .in_negate(in_negate),
    .in_mask_equal(in_mask_equal), .in_mask_sign(in_mask_sign), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .in_ds_present(in_ds_present), .ds_valid(ds_valid),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt)
  );
  // Drives the pre-decoded fields an ID stage would produce; ref_taken comes from the real comparison
  task automatic present(input op_t op, input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt, input logic ds);
    in_valid = 1; in_pc = pc; in_target = tgt; in_pred_taken = pt; in_pred_target = ptgt; in_ds_present = ds;
    in_is_jump = op == JMP;
    in_is_cond = op <= BGEZ;
    in_cond_equal = rs == rt;
    in_cond_sign = rs[31];
    in_mask_equal = op inside {BEQ, BNE, BLEZ, BGTZ};
    in_mask_sign = op inside {BLEZ, BGTZ, BLTZ, BGEZ};
    in_negate = op inside {BNE, BGTZ, BGEZ};
    case (op)
      BEQ: ref_taken = rs == rt;
      BNE: ref_taken = rs != rt;
      BLEZ: ref_taken = $signed(rs) <= 0;
      BGTZ: ref_taken = $signed(rs) > 0;
      BLTZ: ref_taken = $signed(rs) < 0;
      BGEZ: ref_taken = $signed(rs) >= 0;
      JMP: ref_taken = 1;
      default: ref_taken = 0;
    endcase
  endtask
  task automatic model_reset();
    m_st = 0; m_uv = 0; m_ut = 0; m_rpc = 0; m_upc = 0; m_utgt = 0; m_bc = 0; m_mc = 0;
  endtask
  // One clock; model states: 0 idle, 1 waiting for delay slot, 2 redirecting
  task automatic tick();
    logic acc, mis;
    int ns;
    acc = in_valid && m_st == 0 && !flush;
    mis = (ref_taken != in_pred_taken) || (ref_taken && in_pred_target != in_target);
    ns = m_st;
    if (flush) ns = 0;
    else if (m_st == 0 && acc && mis) ns = in_ds_present ? 2 : 1;
    else if (m_st == 1 && ds_valid) ns = 2;
    else if (m_st == 2 && redirect_ready) ns = 0;
    @(posedge clk); #1;
    m_uv = acc;
    if (acc) begin
      m_upc = in_pc; m_utgt = in_target; m_ut = ref_taken; m_bc = m_bc + 1;
      if (mis) begin m_mc = m_mc + 1; m_rpc = ref_taken ? in_target : in_pc + 32'd8; end
    end
    m_st = ns;
  endtask
  task automatic idle();
    in_valid = 0;
  endtask
  task automatic test_reset();
    rst_n = 0; in_valid = 0; in_pc = 0; in_is_cond = 0; in_is_jump = 0; in_target = 0;
    in_cond_equal = 0; in_cond_sign = 0; in_negate = 0; in_mask_equal = 0; in_mask_sign = 0;
    in_pred_taken = 0; in_pred_target = 0; in_ds_present = 0; ds_valid = 0; flush = 0;
    redirect_ready = 0; ref_taken = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    vecs++; if (in_ready !== 1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vecs++; if ({redirect_valid, upd_valid, upd_taken} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b want 000", {redirect_valid, upd_valid, upd_taken}); end
    vecs++; if ({redirect_pc, upd_pc, upd_target} !== 96'd0) begin errs++; $display("FAIL reset_pcs got %h %h %h want 0", redirect_pc, upd_pc, upd_target); end
    vecs++; if ({branch_cnt, mispredict_cnt} !== '0) begin errs++; $display("FAIL reset_cnt got %0d %0d want 0", branch_cnt, mispredict_cnt); end
  endtask
  task automatic test_beq_hit();
    present(BEQ, 32'h11, 32'h11, 32'h1000, 32'h1040, 1, 32'h1040, 1);
    tick(); idle();
    vecs++; if ({upd_valid, upd_taken} !== 2'b11) begin errs++; $display("FAIL beq_upd got v%b t%b want 11", upd_valid, upd_taken); end
    vecs++; if (upd_target !== 32'h1040 || upd_pc !== 32'h1000) begin errs++; $display("FAIL beq_upd_pc got %h %h want 1000 1040", upd_pc, upd_target); end
    vecs++; if (redirect_valid !== 0 || in_ready !== 1) begin errs++; $display("FAIL beq_noredir got rv%b rdy%b want 0 1", redirect_valid, in_ready); end
    vecs++; if (branch_cnt !== 1 || mispredict_cnt !== 0) begin errs++; $display("FAIL beq_cnt got %0d %0d want 1 0", branch_cnt, mispredict_cnt); end
    tick();
    vecs++; if (upd_valid !== 0) begin errs++; $display("FAIL beq_pulse got %b want 0", upd_valid); end
  endtask
  task automatic test_bgtz_hold();
    int n = 0;
    present(BGTZ, 32'd5, 32'd0, 32'h2000, 32'h2100, 0, 32'h0, 1);
    tick(); idle();
    vecs++; if (redirect_valid !== 1 || redirect_pc !== 32'h2100) begin errs++; $display("FAIL bgtz_redir got v%b pc %h want 1 2100", redirect_valid, redirect_pc); end
    vecs++; if (mispredict_cnt !== 1 || in_ready !== 0) begin errs++; $display("FAIL bgtz_cnt got %0d rdy%b want 1 0", mispredict_cnt, in_ready); end
    for (int i = 0; i < 8; i++) begin
      if (redirect_valid) begin
        n++;
        if (redirect_pc !== 32'h2100) begin errs++; $display("FAIL bgtz_stable got %h want 2100", redirect_pc); end
        vecs++;
      end
      redirect_ready = redirect_valid && n == 4;
      tick();
    end
    redirect_ready = 0;
    vecs++; if (n != 4) begin errs++; $display("FAIL bgtz_hold_cycles got %0d want 4", n); end
    vecs++; if (in_ready !== 1) begin errs++; $display("FAIL bgtz_idle got %b want 1", in_ready); end
  endtask
  task automatic test_bne_wait_ds();
    present(BNE, 32'h7, 32'h7, 32'h3000, 32'h3400, 1, 32'h3400, 0);
    tick(); idle();
    vecs++; if (in_ready !== 0 || redirect_valid !== 0) begin errs++; $display("FAIL bne_wait got rdy%b rv%b want 0 0", in_ready, redirect_valid); end
    tick();
    vecs++; if (redirect_valid !== 0) begin errs++; $display("FAIL bne_wait2 got %b want 0", redirect_valid); end
    ds_valid = 1; tick(); ds_valid = 0;
    vecs++; if (redirect_valid !== 1 || redirect_pc !== 32'h3008) begin errs++; $display("FAIL bne_redir got v%b pc %h want 1 3008", redirect_valid, redirect_pc); end
    redirect_ready = 1; tick(); redirect_ready = 0;
    vecs++; if (redirect_valid !== 0 || in_ready !== 1) begin errs++; $display("FAIL bne_release got rv%b rdy%b want 0 1", redirect_valid, in_ready); end
  endtask
  task automatic test_jr_target();
    present(JMP, 0, 0, 32'h7000, 32'h8000, 1, 32'h8004, 1);
    tick(); idle();
    vecs++; if (redirect_valid !== 1 || redirect_pc !== 32'h8000) begin errs++; $display("FAIL jr_redir got v%b pc %h want 1 8000", redirect_valid, redirect_pc); end
    vecs++; if (mispredict_cnt !== m_mc || upd_taken !== 1) begin errs++; $display("FAIL jr_cnt got %0d t%b want %0d 1", mispredict_cnt, upd_taken, m_mc); end
    redirect_ready = 1; tick(); redirect_ready = 0;
  endtask
  task automatic test_flush();
    logic [CW-1:0] bc, mc;
    present(BLTZ, 32'hFFFF_FFF0, 0, 32'h4000, 32'h4800, 0, 0, 1);
    tick(); idle();
    bc = branch_cnt; mc = mispredict_cnt;
    vecs++; if (redirect_valid !== 1) begin errs++; $display("FAIL flush_setup got %b want 1", redirect_valid); end
    flush = 1; redirect_ready = 1; tick(); flush = 0; redirect_ready = 0;
    vecs++; if (redirect_valid !== 0 || in_ready !== 1) begin errs++; $display("FAIL flush_redir got rv%b rdy%b want 0 1", redirect_valid, in_ready); end
    vecs++; if (branch_cnt !== bc || mispredict_cnt !== mc) begin errs++; $display("FAIL flush_cnt got %0d %0d want %0d %0d", branch_cnt, mispredict_cnt, bc, mc); end
    present(BEQ, 1, 2, 32'h4100, 32'h4200, 1, 32'h4200, 1);
    flush = 1; tick(); flush = 0; idle();
    vecs++; if (upd_valid !== 0 || branch_cnt !== bc || in_ready !== 1) begin errs++; $display("FAIL flush_noaccept got uv%b cnt %0d rdy%b want 0 %0d 1", upd_valid, branch_cnt, in_ready, bc); end
    present(BGEZ, 32'hF000_0000, 0, 32'h4300, 32'h4400, 1, 32'h4400, 0);
    tick(); idle();
    ds_valid = 1; flush = 1; tick(); ds_valid = 0; flush = 0;
    vecs++; if (redirect_valid !== 0 || in_ready !== 1) begin errs++; $display("FAIL flush_waitds got rv%b rdy%b want 0 1", redirect_valid, in_ready); end
  endtask
  task automatic test_back_to_back();
    logic [CW-1:0] bc;
    bc = branch_cnt;
    for (int i = 0; i < 5; i++) begin
      present(BEQ, i, 3, 32'h5000 + 32'(i * 16), 32'h6000, i == 3, 32'h6000, 1);
      tick();
      vecs++; if (upd_valid !== 1 || in_ready !== 1 || upd_pc !== 32'h5000 + 32'(i * 16)) begin errs++; $display("FAIL b2b_%0d got uv%b rdy%b pc %h", i, upd_valid, in_ready, upd_pc); end
    end
    idle();
    vecs++; if (branch_cnt !== CW'(bc + 5)) begin errs++; $display("FAIL b2b_cnt got %0d want %0d", branch_cnt, CW'(bc + 5)); end
  endtask
  task automatic test_pc_wrap_and_reset();
    present(BEQ, 1, 2, 32'hFFFF_FFFC, 32'h100, 1, 32'h100, 1);
    tick(); idle();
    vecs++; if (redirect_valid !== 1 || redirect_pc !== 32'h4) begin errs++; $display("FAIL wrap_pc got v%b pc %h want 1 00000004", redirect_valid, redirect_pc); end
    rst_n = 0; #1;
    vecs++; if ({in_ready, redirect_valid, upd_valid, upd_taken} !== 4'b1000) begin errs++; $display("FAIL async_rst_flags got %b want 1000", {in_ready, redirect_valid, upd_valid, upd_taken}); end
    vecs++; if ({redirect_pc, upd_pc, upd_target} !== 96'd0 || {branch_cnt, mispredict_cnt} !== '0) begin errs++; $display("FAIL async_rst_vals got %h %h %h %0d %0d want 0", redirect_pc, upd_pc, upd_target, branch_cnt, mispredict_cnt); end
    model_reset();
    @(posedge clk); #1 rst_n = 1;
  endtask
  task automatic test_random();
    op_t op;
    logic [31:0] rs, rt, tgt;
    for (int c = 0; c < 400; c++) begin
      op = op_t'($urandom_range(0, 7));
      rt = op inside {BLEZ, BGTZ, BLTZ, BGEZ} ? 32'd0 : $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: rs = rt;
        1: rs = 32'hFFFF_FFFF;
        2: rs = $urandom_range(1, 5);
        default: rs = $urandom;
      endcase
      tgt = $urandom;
      present(op, rs, rt, $urandom, tgt, $urandom_range(0, 1), $urandom_range(0, 1) ? tgt : $urandom, $urandom_range(0, 1));
      in_valid = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      ds_valid = $urandom_range(0, 2) == 0;
      redirect_ready = $urandom_range(0, 1);
      tick();
      vecs++; if (in_ready !== (m_st == 0)) begin errs++; $display("FAIL rnd_ready c%0d got %b want %b", c, in_ready, m_st == 0); end
      vecs++; if (redirect_valid !== (m_st == 2)) begin errs++; $display("FAIL rnd_rv c%0d got %b want %b", c, redirect_valid, m_st == 2); end
      vecs++; if (redirect_pc !== m_rpc) begin errs++; $display("FAIL rnd_rpc c%0d got %h want %h", c, redirect_pc, m_rpc); end
      vecs++; if (upd_valid !== m_uv || upd_taken !== m_ut) begin errs++; $display("FAIL rnd_upd c%0d got v%b t%b want v%b t%b", c, upd_valid, upd_taken, m_uv, m_ut); end
      vecs++; if (upd_pc !== m_upc || upd_target !== m_utgt) begin errs++; $display("FAIL rnd_updpc c%0d got %h %h want %h %h", c, upd_pc, upd_target, m_upc, m_utgt); end
      vecs++; if (branch_cnt !== m_bc || mispredict_cnt !== m_mc) begin errs++; $display("FAIL rnd_cnt c%0d got %0d %0d want %0d %0d", c, branch_cnt, mispredict_cnt, m_bc, m_mc); end
    end
    idle(); flush = 0; ds_valid = 0; redirect_ready = 0;
  endtask
  initial begin
    test_reset();
    test_beq_hit();
    test_bgtz_hold();
    test_bne_wait_ds();
    test_jr_target();
    test_flush();
    test_back_to_back();
    test_pc_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
